prog_clkdiv: RTL and testbench

Multi-channel programmable clock divider: each channel divides `clkin` by a runtime-loadable integer divisor and drives a square-wave `clkout` plus a one-cycle end-of-period `tick`. It generalises the fixed ÷2000 note-period divider. Divisor changes go through a shadow register and take effect only at a period boundary, so tone changes are glitch-free. It sits between the note/sequencer logic and the tone and beat outputs.

---
 rtl/prog_clkdiv_pkg.sv | 14 +
 rtl/prog_clkdiv_if.sv | 29 ++
 rtl/prog_clkdiv_chan.sv | 107 ++++++++++
 rtl/prog_clkdiv.sv | 50 +++++
 tb/tb_prog_clkdiv.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_clkdiv_pkg.sv
// rtl/prog_clkdiv_pkg.sv - shared defaults, divisor type and legality helper for prog_clkdiv
package prog_clkdiv_pkg;

    localparam int unsigned CLKDIV_DEF_W   = 32;
    localparam int unsigned CLKDIV_DEF_DIV = 2000;

    typedef logic [CLKDIV_DEF_W-1:0] div_t;

    // A divisor below 2 cannot form a high and a low phase, so the channel stops.
    function automatic logic legal_div(input logic [63:0] d);
        return d >= 64'd2;
    endfunction

endpackage

// File: rtl/prog_clkdiv_if.sv
// rtl/prog_clkdiv_if.sv - control/status bundle of prog_clkdiv (duty_in only with PROG_CLKDIV_DUTY_EN)
interface prog_clkdiv_if
    import prog_clkdiv_pkg::*;
#(
    parameter int unsigned CH = 4,
    parameter int unsigned W  = CLKDIV_DEF_W
);
    localparam int unsigned SW = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0] en;
    logic          load;
    logic [SW-1:0] ch_sel;
    logic [W-1:0]  div_in;
`ifdef PROG_CLKDIV_DUTY_EN
    logic [W-1:0]  duty_in;
`endif
    logic [CH-1:0] clkout;
    logic [CH-1:0] tick;
    logic [CH-1:0] pending;

`ifdef PROG_CLKDIV_DUTY_EN
    modport master (output en, load, ch_sel, div_in, duty_in, input clkout, tick, pending);
    modport slave  (input en, load, ch_sel, div_in, duty_in, output clkout, tick, pending);
`else
    modport master (output en, load, ch_sel, div_in, input clkout, tick, pending);
    modport slave  (input en, load, ch_sel, div_in, output clkout, tick, pending);
`endif

endinterface

// File: rtl/prog_clkdiv_chan.sv
// rtl/prog_clkdiv_chan.sv - one divider channel: counter, shadow/active divisor, registered outputs (PROG_CLKDIV_DUTY_EN adds duty)
module prog_clkdiv_chan
    import prog_clkdiv_pkg::*;
#(
    parameter int unsigned W       = CLKDIV_DEF_W,
    parameter int unsigned DEF_DIV = CLKDIV_DEF_DIV
) (
    input  logic         clkin,
    input  logic         reset,
    input  logic         en,
    input  logic         wr,
    input  logic [W-1:0] div_in,
`ifdef PROG_CLKDIV_DUTY_EN
    input  logic [W-1:0] duty_in,
`endif
    output logic         clkout,
    output logic         tick,
    output logic         pending
);

    localparam logic [W-1:0] RST_DIV = W'(DEF_DIV);

    logic [W-1:0] count;
    logic [W-1:0] active_div;
    logic [W-1:0] shadow_div;
    logic         pend;
    logic         running;
    logic         boundary;
    logic         apply;
    logic [W-1:0] high_lim;

`ifdef PROG_CLKDIV_DUTY_EN
    localparam logic [W-1:0] RST_DUTY = W'(DEF_DIV >> 1);
    logic [W-1:0] active_duty;
    logic [W-1:0] shadow_duty;
`endif

    // Run/wrap decode; a stopped or idle channel is always at a period boundary.
    always_comb begin
        running  = en && legal_div(64'(active_div));
        boundary = !running || (count == '0) || (count >= active_div);
        apply    = pend && boundary;
`ifdef PROG_CLKDIV_DUTY_EN
        high_lim = (active_duty < active_div) ? active_duty : active_div;
`else
        high_lim = active_div >> 1;
`endif
    end

    // Period counter: 0 = idle, otherwise 1..active_div.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!running) begin
            count <= '0;
        end else if (boundary) begin
            count <= W'(1);
        end else begin
            count <= count + W'(1);
        end
    end

    // Shadow/active divisor; a same-cycle write stays pending behind the value being applied.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            active_div  <= RST_DIV;
            shadow_div  <= RST_DIV;
            pend        <= 1'b0;
`ifdef PROG_CLKDIV_DUTY_EN
            active_duty <= RST_DUTY;
            shadow_duty <= RST_DUTY;
`endif
        end else begin
            if (apply) begin
                active_div  <= shadow_div;
`ifdef PROG_CLKDIV_DUTY_EN
                active_duty <= shadow_duty;
`endif
            end
            if (wr) begin
                shadow_div  <= div_in;
`ifdef PROG_CLKDIV_DUTY_EN
                shadow_duty <= duty_in;
`endif
            end
            if (wr) begin
                pend <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

    // Output stage one register behind the counter, forced low when not running.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            clkout <= 1'b0;
            tick   <= 1'b0;
        end else begin
            clkout <= running && (count != '0) && (count <= high_lim);
            tick   <= running && (count != '0) && (count == active_div);
        end
    end

    assign pending = pend;

endmodule

// File: rtl/prog_clkdiv.sv
// rtl/prog_clkdiv.sv - multi-channel programmable clock divider top (PROG_CLKDIV_DUTY_EN enables duty control)
module prog_clkdiv
    import prog_clkdiv_pkg::*;
#(
    parameter int unsigned CH      = 4,
    parameter int unsigned W       = CLKDIV_DEF_W,
    parameter int unsigned DEF_DIV = CLKDIV_DEF_DIV
) (
    input  logic         clkin,
    input  logic         reset,
    prog_clkdiv_if.slave bus
);

    logic [CH-1:0] wr;
    logic [CH-1:0] clk_v;
    logic [CH-1:0] tick_v;
    logic [CH-1:0] pend_v;

    // Decode the load strobe to one channel; selects beyond CH match nothing.
    always_comb begin
        wr = '0;
        for (int i = 0; i < CH; i++) begin
            wr[i] = bus.load && (32'(bus.ch_sel) == 32'(i));
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_chan
        prog_clkdiv_chan #(
            .W       (W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clkin   (clkin),
            .reset   (reset),
            .en      (bus.en[g]),
            .wr      (wr[g]),
            .div_in  (bus.div_in),
`ifdef PROG_CLKDIV_DUTY_EN
            .duty_in (bus.duty_in),
`endif
            .clkout  (clk_v[g]),
            .tick    (tick_v[g]),
            .pending (pend_v[g])
        );
    end

    assign bus.clkout  = clk_v;
    assign bus.tick    = tick_v;
    assign bus.pending = pend_v;

endmodule

// File: tb/tb_prog_clkdiv.sv
// tb/tb_prog_clkdiv.sv - self-checking bench for prog_clkdiv (PROG_CLKDIV_DUTY_EN adds duty scenario)
module tb_prog_clkdiv;

    localparam int CH      = 3;
    localparam int W       = 32;
    localparam int DEF_DIV = 2000;

    logic clkin = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    prog_clkdiv_if #(.CH(CH), .W(W)) bus ();

    prog_clkdiv #(.CH(CH), .W(W), .DEF_DIV(DEF_DIV)) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    // Reference: each channel is a position within its current period plus divisor bookkeeping.
    typedef struct {
        int act;
        int shd;
        int dact;
        int dshd;
        int pos;
        bit pnd;
        bit clk;
        bit tck;
    } mch_t;

    mch_t m [CH];

    function automatic mch_t model_init();
        mch_t s;
        s.act = DEF_DIV; s.shd = DEF_DIV;
        s.dact = DEF_DIV / 2; s.dshd = DEF_DIV / 2;
        s.pos = 0; s.pnd = 1'b0; s.clk = 1'b0; s.tck = 1'b0;
        return s;
    endfunction

    function automatic mch_t model_step(mch_t s, bit e, bit wr, int d, int du);
        mch_t n;
        bit   going;
        bit   at_end;
        int   high;
        n      = s;
        going  = e && (s.act >= 2);
        at_end = !going || s.pos == 0 || s.pos == s.act;
`ifdef PROG_CLKDIV_DUTY_EN
        high = (s.dact < s.act) ? s.dact : s.act;
`else
        high = s.act / 2;
`endif
        n.clk = going && s.pos >= 1 && s.pos <= high;
        n.tck = going && s.pos == s.act;
        n.pos = !going ? 0 : (at_end ? 1 : s.pos + 1);
        if (s.pnd && at_end) begin
            n.act = s.shd; n.dact = s.dshd; n.pnd = 1'b0;
        end
        if (wr) begin
            n.shd = d; n.dshd = du; n.pnd = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clkin or negedge reset) begin
        for (int c = 0; c < CH; c++) begin
            if (!reset) begin
                m[c] <= model_init();
            end else begin
`ifdef PROG_CLKDIV_DUTY_EN
                m[c] <= model_step(m[c], bus.en[c], bus.load && int'(bus.ch_sel) == c,
                                   int'(bus.div_in), int'(bus.duty_in));
`else
                m[c] <= model_step(m[c], bus.en[c], bus.load && int'(bus.ch_sel) == c,
                                   int'(bus.div_in), 0);
`endif
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic do_load(input int c, input int d, input int du);
        bus.load   = 1'b1;
        bus.ch_sel = 2'(c);
        bus.div_in = 32'(d);
`ifdef PROG_CLKDIV_DUTY_EN
        bus.duty_in = 32'(du);
`else
        if (du < 0) bus.div_in = 32'(d);
`endif
        @(negedge clkin);
        bus.load = 1'b0;
    endtask

    task automatic wait_unpend(input int c, input int bound, output int waited);
        waited = 0;
        while (bus.pending[c] === 1'b1 && waited < bound) begin
            @(negedge clkin);
            waited++;
        end
    endtask

    task automatic measure_wave(input int c, output int hi, output int lo);
        int g;
        hi = -1; lo = -1; g = 0;
        while (bus.clkout[c] !== 1'b0 && g < 5000) begin @(negedge clkin); g++; end
        while (bus.clkout[c] !== 1'b1 && g < 5000) begin @(negedge clkin); g++; end
        if (g >= 5000) return;
        hi = 0;
        while (bus.clkout[c] === 1'b1 && hi < 5000) begin hi++; @(negedge clkin); end
        lo = 0;
        while (bus.clkout[c] === 1'b0 && lo < 5000) begin lo++; @(negedge clkin); end
    endtask

    task automatic measure_tick(input int c, output int per);
        int g;
        g = 0; per = -1;
        while (bus.tick[c] !== 1'b1 && g < 5000) begin @(negedge clkin); g++; end
        if (g >= 5000) return;
        @(negedge clkin);
        per = 1;
        while (bus.tick[c] !== 1'b1 && per < 5000) begin @(negedge clkin); per++; end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.en = '0; bus.load = 1'b0; bus.ch_sel = '0; bus.div_in = '0;
`ifdef PROG_CLKDIV_DUTY_EN
        bus.duty_in = '0;
`endif
        #3;
        n_vec++; if (bus.clkout !== 3'b000) begin n_bad++; $display("FAIL reset_clkout got %b want 000", bus.clkout); end
        n_vec++; if (bus.tick !== 3'b000) begin n_bad++; $display("FAIL reset_tick got %b want 000", bus.tick); end
        n_vec++; if (bus.pending !== 3'b000) begin n_bad++; $display("FAIL reset_pending got %b want 000", bus.pending); end
        cycles(2);
        reset = 1'b1;
        cycles(3);
        n_vec++; if (bus.clkout !== 3'b000) begin n_bad++; $display("FAIL idle_clkout got %b want 000", bus.clkout); end
    endtask

    task automatic test_default_div();
        int hi, lo, per;
        bus.en[0] = 1'b1;
        @(negedge clkin);
        n_vec++; if (bus.clkout[0] !== 1'b0) begin n_bad++; $display("FAIL first_cycle_low got %b want 0", bus.clkout[0]); end
        @(negedge clkin);
        n_vec++; if (bus.clkout[0] !== 1'b1) begin n_bad++; $display("FAIL second_cycle_high got %b want 1", bus.clkout[0]); end
        measure_wave(0, hi, lo);
        n_vec++; if (hi !== 1000) begin n_bad++; $display("FAIL def_high got %0d want 1000", hi); end
        n_vec++; if (lo !== 1000) begin n_bad++; $display("FAIL def_low got %0d want 1000", lo); end
        measure_tick(0, per);
        n_vec++; if (per !== 2000) begin n_bad++; $display("FAIL def_tick_period got %0d want 2000", per); end
        n_vec++; if (bus.pending[0] !== 1'b0) begin n_bad++; $display("FAIL def_pending got %b want 0", bus.pending[0]); end
    endtask

    task automatic test_load_midperiod();
        int waited, hi, lo, per;
        bus.en[1] = 1'b1;
        cycles(500);
        do_load(1, 7, 3);
        n_vec++; if (bus.pending[1] !== 1'b1) begin n_bad++; $display("FAIL mid_pending_set got %b want 1", bus.pending[1]); end
        wait_unpend(1, 2100, waited);
        n_vec++; if (waited !== 1500) begin n_bad++; $display("FAIL mid_pending_cycles got %0d want 1500", waited); end
        measure_wave(1, hi, lo);
        n_vec++; if (hi !== 3) begin n_bad++; $display("FAIL div7_high got %0d want 3", hi); end
        n_vec++; if (lo !== 4) begin n_bad++; $display("FAIL div7_low got %0d want 4", lo); end
        measure_tick(1, per);
        n_vec++; if (per !== 7) begin n_bad++; $display("FAIL div7_tick got %0d want 7", per); end
    endtask

    task automatic test_last_wins();
        int waited, hi, lo, per, g;
        bus.en[2] = 1'b1;
        cycles(100);
        do_load(2, 5, 2);
        do_load(2, 9, 4);
        wait_unpend(2, 2100, waited);
        n_vec++; if (bus.pending[2] !== 1'b0) begin n_bad++; $display("FAIL lw_pending got %b want 0", bus.pending[2]); end
        measure_tick(2, per);
        n_vec++; if (per !== 9) begin n_bad++; $display("FAIL lw_tick got %0d want 9", per); end
        measure_wave(2, hi, lo);
        n_vec++; if (hi !== 4 || lo !== 5) begin n_bad++; $display("FAIL lw_wave got %0d/%0d want 4/5", hi, lo); end
        // Load 5 mid-period, then 6 exactly on the wrap cycle.
        g = 0;
        while (bus.tick[2] !== 1'b1 && g < 20) begin @(negedge clkin); g++; end
        cycles(2);
        do_load(2, 5, 2);
        cycles(5);
        do_load(2, 6, 3);
        n_vec++; if (bus.tick[2] !== 1'b1) begin n_bad++; $display("FAIL wrap_tick got %b want 1", bus.tick[2]); end
        n_vec++; if (bus.pending[2] !== 1'b1) begin n_bad++; $display("FAIL wrap_still_pending got %b want 1", bus.pending[2]); end
        cycles(4);
        n_vec++; if (bus.tick[2] !== 1'b0 || bus.pending[2] !== 1'b1) begin
            n_bad++; $display("FAIL wrap_mid5 got tick=%b pend=%b want 0/1", bus.tick[2], bus.pending[2]);
        end
        cycles(1);
        n_vec++; if (bus.tick[2] !== 1'b1 || bus.pending[2] !== 1'b0) begin
            n_bad++; $display("FAIL wrap_end5 got tick=%b pend=%b want 1/0", bus.tick[2], bus.pending[2]);
        end
        measure_tick(2, per);
        n_vec++; if (per !== 6) begin n_bad++; $display("FAIL wrap_next_tick got %0d want 6", per); end
    endtask

    task automatic test_illegal_div();
        int waited, hi, lo;
        int bad;
        do_load(1, 1, 0);
        wait_unpend(1, 20, waited);
        n_vec++; if (bus.pending[1] !== 1'b0) begin n_bad++; $display("FAIL div1_apply got %b want 0", bus.pending[1]); end
        cycles(2);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.clkout[1] !== 1'b0 || bus.tick[1] !== 1'b0) bad++;
            @(negedge clkin);
        end
        n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL div1_quiet got %0d active samples want 0", bad); end
        do_load(1, 0, 0);
        wait_unpend(1, 5, waited);
        n_vec++; if (bus.pending[1] !== 1'b0) begin n_bad++; $display("FAIL div0_apply got %b want 0", bus.pending[1]); end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.clkout[1] !== 1'b0 || bus.tick[1] !== 1'b0) bad++;
            @(negedge clkin);
        end
        n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL div0_quiet got %0d active samples want 0", bad); end
        bus.en[1] = 1'b0;
        do_load(1, 4, 2);
        n_vec++; if (bus.pending[1] !== 1'b1) begin n_bad++; $display("FAIL dis_load_pending got %b want 1", bus.pending[1]); end
        cycles(1);
        n_vec++; if (bus.pending[1] !== 1'b0) begin n_bad++; $display("FAIL dis_load_applied got %b want 0", bus.pending[1]); end
        bus.en[1] = 1'b1;
        @(negedge clkin);
        n_vec++; if (bus.clkout[1] !== 1'b0) begin n_bad++; $display("FAIL div4_first got %b want 0", bus.clkout[1]); end
        @(negedge clkin);
        n_vec++; if (bus.clkout[1] !== 1'b1) begin n_bad++; $display("FAIL div4_second got %b want 1", bus.clkout[1]); end
        measure_wave(1, hi, lo);
        n_vec++; if (hi !== 2 || lo !== 2) begin n_bad++; $display("FAIL div4_wave got %0d/%0d want 2/2", hi, lo); end
    endtask

    task automatic test_reset_midperiod();
        int g, hi, lo;
        g = 0;
        while (bus.clkout[0] !== 1'b1 && g < 2100) begin @(negedge clkin); g++; end
        cycles(300);
        bus.en[0] = 1'b0;
        @(negedge clkin);
        n_vec++; if (bus.clkout[0] !== 1'b0 || bus.tick[0] !== 1'b0) begin
            n_bad++; $display("FAIL en_drop got clk=%b tick=%b want 0/0", bus.clkout[0], bus.tick[0]);
        end
        bus.en[0] = 1'b1;
        measure_wave(0, hi, lo);
        n_vec++; if (hi !== 1000 || lo !== 1000) begin n_bad++; $display("FAIL restart_wave got %0d/%0d want 1000/1000", hi, lo); end
        cycles(200);
        do_load(2, 11, 5);
        #2 reset = 1'b0;
        #1;
        n_vec++; if (bus.clkout !== 3'b000 || bus.tick !== 3'b000) begin
            n_bad++; $display("FAIL async_reset got clk=%b tick=%b want 000/000", bus.clkout, bus.tick);
        end
        n_vec++; if (bus.pending !== 3'b000) begin n_bad++; $display("FAIL async_reset_pend got %b want 000", bus.pending); end
        @(negedge clkin);
        reset = 1'b1;
        measure_wave(0, hi, lo);
        n_vec++; if (hi !== 1000 || lo !== 1000) begin n_bad++; $display("FAIL post_reset_wave got %0d/%0d want 1000/1000", hi, lo); end
    endtask

    task automatic test_random();
        bus.en = '1;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < CH; c++) begin
                n_vec++; if (bus.clkout[c] !== m[c].clk) begin
                    n_bad++; $display("FAIL rnd_clkout ch%0d cyc%0d got %b want %b", c, k, bus.clkout[c], m[c].clk);
                end
                n_vec++; if (bus.tick[c] !== m[c].tck) begin
                    n_bad++; $display("FAIL rnd_tick ch%0d cyc%0d got %b want %b", c, k, bus.tick[c], m[c].tck);
                end
                n_vec++; if (bus.pending[c] !== m[c].pnd) begin
                    n_bad++; $display("FAIL rnd_pending ch%0d cyc%0d got %b want %b", c, k, bus.pending[c], m[c].pnd);
                end
                if ($urandom_range(0, 31) == 0) bus.en[c] = ~bus.en[c];
            end
            bus.load   = ($urandom_range(0, 5) == 0);
            bus.ch_sel = 2'($urandom_range(0, 3));
            bus.div_in = 32'($urandom_range(0, 12));
`ifdef PROG_CLKDIV_DUTY_EN
            bus.duty_in = 32'($urandom_range(0, 14));
`endif
            @(negedge clkin);
        end
        bus.load = 1'b0;
    endtask

`ifdef PROG_CLKDIV_DUTY_EN
    task automatic test_duty();
        int waited, hi, lo, per, bad;
        bus.en = '1;
        do_load(0, 10, 3);
        wait_unpend(0, 5000, waited);
        measure_wave(0, hi, lo);
        n_vec++; if (hi !== 3 || lo !== 7) begin n_bad++; $display("FAIL duty3_wave got %0d/%0d want 3/7", hi, lo); end
        measure_tick(0, per);
        n_vec++; if (per !== 10) begin n_bad++; $display("FAIL duty3_tick got %0d want 10", per); end
        do_load(0, 10, 12);
        wait_unpend(0, 20, waited);
        cycles(2);
        bad = 0;
        for (int k = 0; k < 25; k++) begin
            if (bus.clkout[0] !== 1'b1) bad++;
            @(negedge clkin);
        end
        n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL duty12_high got %0d low samples want 0", bad); end
        measure_tick(0, per);
        n_vec++; if (per !== 10) begin n_bad++; $display("FAIL duty12_tick got %0d want 10", per); end
    endtask
`endif

    initial begin
        test_reset();
        test_default_div();
        test_load_midperiod();
        test_last_wins();
        test_illegal_div();
        test_reset_midperiod();
        test_random();
`ifdef PROG_CLKDIV_DUTY_EN
        test_duty();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
